// File: rtl/spi_reg_bank.sv
// Register bank written and read over an SPI slave byte interface.
// Strobes arrive from another clock domain; committed registers only change atomically.
module spi_reg_bank #(
  parameter int unsigned            NUM_REGS  = 2,
  parameter int unsigned            REG_BYTES = 1,
  parameter logic [3:0]             PERIPH_ID = 4'b0001,
  parameter logic [REG_BYTES*8-1:0] RST_VAL   = '1
) (
  input  logic                            iCLK,
  input  logic                            iRESETn,
  input  logic                            iSPI_WRITE_SIG,
  input  logic                            iSPI_SS_N,
  input  logic [7:0]                      iSPI_RCV_CMD,
  input  logic [7:0]                      iSPI_RCV_BYTE,
  output logic [NUM_REGS*REG_BYTES*8-1:0] oREG_DATA,
  output logic [NUM_REGS-1:0]             oREG_UPDATE,
  output logic [7:0]                      oSEND_BYTE,
  output logic                            oERR
);
  localparam int unsigned W    = REG_BYTES * 8;
  localparam logic [1:0]  LAST = 2'(REG_BYTES - 1);
  localparam logic [2:0]  NR   = 3'(NUM_REGS);

  logic ws_s1, ws_s2, ws_d;
  logic ss_s1, ss_s2, ss_d;
  logic [2:0] vld;
  logic in_frame;
  logic strobe, frame_start, frame_end, accept;
  logic is_read, idx_ok, idx_stat;
  logic [2:0] idx;
  logic [1:0] bp, rp;
  logic [REG_BYTES-1:0][7:0] shadow, shadow_next, commit_buf;
  logic [NUM_REGS-1:0][W-1:0] regs;
  logic commit_pend;
  logic [2:0] commit_idx;
  logic [7:0] rd_byte;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      ws_s1 <= 1'b0;
      ws_s2 <= 1'b0;
      ws_d  <= 1'b0;
      ss_s1 <= 1'b1;
      ss_s2 <= 1'b1;
      ss_d  <= 1'b1;
      vld   <= '0;
    end else begin
      ws_s1 <= iSPI_WRITE_SIG;
      ws_s2 <= ws_s1;
      ws_d  <= ws_s2;
      ss_s1 <= iSPI_SS_N;
      ss_s2 <= ss_s1;
      ss_d  <= ss_s2;
      vld   <= {vld[1:0], 1'b1};
    end
  end

  // A falling SS_N only counts once the synchroniser holds real samples, so a
  // line already low at reset release does not open a frame.
  assign strobe      = ws_s2 & ~ws_d;
  assign frame_start = vld[2] & ss_d & ~ss_s2;
  assign frame_end   = ss_s2 & ~ss_d;
  assign accept      = strobe & in_frame & (iSPI_RCV_CMD[6:3] == PERIPH_ID);

  assign is_read  = iSPI_RCV_CMD[7];
  assign idx      = iSPI_RCV_CMD[2:0];
  assign idx_stat = (idx == 3'd7);
  assign idx_ok   = (idx < NR);

  always_comb begin
    shadow_next = shadow;
    for (int unsigned b = 0; b < REG_BYTES; b++)
      if (bp == 2'(b)) shadow_next[b] = iSPI_RCV_BYTE;
  end

  always_comb begin
    rd_byte = '0;
    if (idx_stat) begin
      rd_byte = {oERR, 3'b000, 2'b00, bp};
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        for (int unsigned b = 0; b < REG_BYTES; b++)
          if (idx == 3'(r) && rp == 2'(b)) rd_byte = regs[r][b*8 +: 8];
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      in_frame <= 1'b0;
    end else if (frame_start) begin
      in_frame <= 1'b1;
    end else if (frame_end) begin
      in_frame <= 1'b0;
    end
  end

  // The completed word is latched into commit_buf at the strobe so that a
  // frame end in the same cycle can clear the shadow without losing it.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= RST_VAL;
      oREG_UPDATE <= '0;
      oSEND_BYTE  <= '0;
      oERR        <= 1'b0;
      bp          <= '0;
      rp          <= '0;
      shadow      <= '0;
      commit_buf  <= '0;
      commit_pend <= 1'b0;
      commit_idx  <= '0;
    end else begin
      oREG_UPDATE <= '0;
      commit_pend <= 1'b0;
      if (commit_pend) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (commit_idx == 3'(r)) begin
            regs[r]        <= commit_buf;
            oREG_UPDATE[r] <= 1'b1;
          end
        end
      end
      if (accept) begin
        if (!is_read) begin
          oSEND_BYTE <= '0;
          if (idx_ok) begin
            if (bp == LAST) begin
              commit_buf  <= shadow_next;
              commit_pend <= 1'b1;
              commit_idx  <= idx;
              shadow      <= '0;
              bp          <= '0;
            end else begin
              shadow <= shadow_next;
              bp     <= bp + 2'd1;
            end
          end else if (!idx_stat) begin
            oERR <= 1'b1;
          end
        end else begin
          oSEND_BYTE <= rd_byte;
          rp         <= (rp == LAST) ? 2'd0 : rp + 2'd1;
          if (idx_stat) oERR <= 1'b0;
          else if (!idx_ok) oERR <= 1'b1;
        end
      end
      if (frame_end) begin
        bp     <= '0;
        rp     <= '0;
        shadow <= '0;
        if (!accept) oSEND_BYTE <= '0;
      end
    end
  end

  assign oREG_DATA = regs;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: a 1-byte and a 2-byte bank share one SPI stimulus
// stream and are compared against a byte-level reference model.
module tb_spi_reg_bank;
  logic clk, rst_n, wsig, ss_n;
  logic [7:0] spi_cmd, spi_byte;
  logic [15:0] d0;
  logic [31:0] d1;
  logic [1:0]  upd0, upd1;
  logic [7:0]  send0, send1;
  logic        err0, err1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model, index k: 0 = 1-byte bank, 1 = 2-byte bank.
  logic [15:0] m_reg [2][2];
  logic [7:0]  m_sh  [2][2];
  int unsigned m_bp [2];
  int unsigned m_rp [2];
  logic        m_err [2];
  logic [7:0]  m_send [2];
  logic [1:0]  m_upd [2];
  logic        m_inframe;

  spi_reg_bank #(.NUM_REGS(2), .REG_BYTES(1)) u_dut0 (
    .iCLK(clk), .iRESETn(rst_n), .iSPI_WRITE_SIG(wsig), .iSPI_SS_N(ss_n),
    .iSPI_RCV_CMD(spi_cmd), .iSPI_RCV_BYTE(spi_byte),
    .oREG_DATA(d0), .oREG_UPDATE(upd0), .oSEND_BYTE(send0), .oERR(err0)
  );

  spi_reg_bank #(.NUM_REGS(2), .REG_BYTES(2)) u_dut1 (
    .iCLK(clk), .iRESETn(rst_n), .iSPI_WRITE_SIG(wsig), .iSPI_SS_N(ss_n),
    .iSPI_RCV_CMD(spi_cmd), .iSPI_RCV_BYTE(spi_byte),
    .oREG_DATA(d1), .oREG_UPDATE(upd1), .oSEND_BYTE(send1), .oERR(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_d0();
    return {m_reg[0][1][7:0], m_reg[0][0][7:0]};
  endfunction

  function automatic logic [31:0] exp_d1();
    return {m_reg[1][1], m_reg[1][0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        m_reg[k][r] = (k == 0) ? 16'h00FF : 16'hFFFF;
        m_sh[k][r]  = 8'h00;
      end
      m_bp[k] = 0; m_rp[k] = 0; m_err[k] = 1'b0; m_send[k] = 8'h00; m_upd[k] = 2'b00;
    end
    m_inframe = 1'b0;
  endtask

  task automatic model_strobe(input logic [7:0] cmd, input logic [7:0] data);
    int unsigned idx, rb;
    idx = int'(cmd[2:0]);
    for (int k = 0; k < 2; k++) begin
      m_upd[k] = 2'b00;
      rb = k + 1;
      if (!m_inframe || cmd[6:3] != 4'd1) continue;
      if (!cmd[7]) begin
        m_send[k] = 8'h00;
        if (idx < 2) begin
          m_sh[k][m_bp[k]] = data;
          if (m_bp[k] == rb - 1) begin
            m_reg[k][idx] = (rb == 1) ? {8'h00, m_sh[k][0]} : {m_sh[k][1], m_sh[k][0]};
            m_upd[k] = 2'(1 << idx);
            m_bp[k] = 0;
            m_sh[k][0] = 8'h00;
            m_sh[k][1] = 8'h00;
          end else begin
            m_bp[k]++;
          end
        end else if (idx != 7) begin
          m_err[k] = 1'b1;
        end
      end else begin
        if (idx == 7) begin
          m_send[k] = {m_err[k], 5'b00000, 2'(m_bp[k])};
          m_err[k] = 1'b0;
        end else if (idx < 2) begin
          m_send[k] = m_reg[k][idx][8*m_rp[k] +: 8];
        end else begin
          m_send[k] = 8'h00;
          m_err[k] = 1'b1;
        end
        m_rp[k] = (m_rp[k] + 1) % rb;
      end
    end
  endtask

  task automatic check_steady();
    chk("data0", {16'h0, d0}, {16'h0, exp_d0()});
    chk("data1", d1, exp_d1());
    chk("upd0_idle", {30'h0, upd0}, 32'h0);
    chk("upd1_idle", {30'h0, upd1}, 32'h0);
    chk("send0", {24'h0, send0}, {24'h0, m_send[0]});
    chk("send1", {24'h0, send1}, {24'h0, m_send[1]});
    chk("err0", {31'h0, err0}, {31'h0, m_err[0]});
    chk("err1", {31'h0, err1}, {31'h0, m_err[1]});
  endtask

  // One SPI byte: strobe seen on edge 1, commit visible after edge 4.
  task automatic send_byte(input logic [7:0] cmd, input logic [7:0] data);
    logic [15:0] pre0;
    logic [31:0] pre1;
    pre0 = exp_d0();
    pre1 = exp_d1();
    model_strobe(cmd, data);
    @(negedge clk);
    spi_cmd = cmd; spi_byte = data; wsig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("data0_e3", {16'h0, d0}, {16'h0, pre0});
    chk("data1_e3", d1, pre1);
    chk("upd0_e3", {30'h0, upd0}, 32'h0);
    chk("upd1_e3", {30'h0, upd1}, 32'h0);
    chk("send0_e3", {24'h0, send0}, {24'h0, m_send[0]});
    chk("send1_e3", {24'h0, send1}, {24'h0, m_send[1]});
    chk("err0_e3", {31'h0, err0}, {31'h0, m_err[0]});
    chk("err1_e3", {31'h0, err1}, {31'h0, m_err[1]});
    @(posedge clk);
    #1;
    chk("data0_e4", {16'h0, d0}, {16'h0, exp_d0()});
    chk("data1_e4", d1, exp_d1());
    chk("upd0_e4", {30'h0, upd0}, {30'h0, m_upd[0]});
    chk("upd1_e4", {30'h0, upd1}, {30'h0, m_upd[1]});
    @(posedge clk);
    #1;
    chk("upd0_e5", {30'h0, upd0}, 32'h0);
    chk("upd1_e5", {30'h0, upd1}, 32'h0);
    @(negedge clk);
    wsig = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_set(input logic active);
    logic was_high;
    was_high = ss_n;
    @(negedge clk);
    ss_n = ~active;
    repeat (5) @(negedge clk);
    if (active) begin
      if (was_high) m_inframe = 1'b1;
    end else begin
      m_inframe = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_bp[k] = 0; m_rp[k] = 0; m_send[k] = 8'h00;
        m_sh[k][0] = 8'h00; m_sh[k][1] = 8'h00;
      end
    end
    check_steady();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_steady();
    chk("rst_data0", {16'h0, d0}, 32'h0000FFFF);
    chk("rst_data1", d1, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_steady();
  endtask

  initial begin
    logic [7:0] cmd;
    logic [3:0] id;
    logic [2:0] ridx;
    int unsigned op;
    rst_n = 1'b0; wsig = 1'b0; ss_n = 1'b1; spi_cmd = 8'h00; spi_byte = 8'h00;
    model_reset();

    do_reset();
    frame_set(1'b1);

    // single-byte write to register 1
    send_byte(8'h09, 8'h5A);
    chk("dir_reg1_5a", {24'h0, d0[15:8]}, 32'h5A);
    send_byte(8'h09, 8'hC3);

    // two-byte write, visible only after the second byte
    send_byte(8'h08, 8'h34);
    chk("dir_partial", {16'h0, d1[15:0]}, 32'hFFFF);
    send_byte(8'h08, 8'h12);
    chk("dir_1234", {16'h0, d1[15:0]}, 32'h1234);

    // aborted partial write, next frame restarts at byte 0
    send_byte(8'h08, 8'h77);
    frame_set(1'b0);
    frame_set(1'b1);
    send_byte(8'h08, 8'hAA);
    send_byte(8'h08, 8'hBB);
    chk("dir_bbaa", {16'h0, d1[15:0]}, 32'hBBAA);

    // unimplemented index, then status read clears the error
    send_byte(8'h0D, 8'h00);
    chk("dir_err_set", {31'h0, err0}, 32'h1);
    send_byte(8'h8F, 8'h00);
    chk("dir_status0", {24'h0, send0}, 32'h80);
    chk("dir_status1", {24'h0, send1}, 32'h80);
    chk("dir_err_clr", {31'h0, err0}, 32'h0);

    // readback and foreign peripheral id
    send_byte(8'h08, 8'hA5);
    send_byte(8'h88, 8'h00);
    chk("dir_read_a5", {24'h0, send0}, 32'hA5);
    send_byte(8'h28, 8'h55);
    chk("dir_foreign", {16'h0, d0}, {16'h0, exp_d0()});

    // reset between the bytes of a two-byte write
    frame_set(1'b0);
    frame_set(1'b1);
    send_byte(8'h08, 8'h34);
    do_reset();
    send_byte(8'h08, 8'h12);
    chk("dir_post_rst", d1, 32'hFFFFFFFF);
    frame_set(1'b0);
    frame_set(1'b1);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      ridx = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      if (op == 0) begin
        frame_set(ss_n);
      end else if (op == 1) begin
        id = 4'($urandom_range(0, 15));
        if (id == 4'd1) id = 4'd2;
        cmd = {1'($urandom_range(0, 1)), id, ridx};
        send_byte(cmd, 8'($urandom));
      end else if (op < 6) begin
        send_byte({1'b0, 4'd1, ridx}, 8'($urandom));
      end else begin
        send_byte({1'b1, 4'd1, ridx}, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 2, giving the number of writable registers (legal range 1..7).
REQ-002 The block SHALL have parameter REG_BYTES, default 1, giving bytes per register (legal range 1..4).
REQ-003 The block SHALL have parameter PERIPH_ID, default 4'b0001, giving the command peripheral field this bank answers to.
REQ-004 The block SHALL have parameter RST_VAL, default all-ones, giving the reset value of every register (width REG_BYTES*8).
REQ-005 Port: iCLK  input  1  system clock; one clock, all state on rising edge.
REQ-006 Port: iRESETn  input  1  reset, asynchronous and active-low.
REQ-007 Port: iSPI_WRITE_SIG  input  1  byte-received strobe from the SPI slave, asynchronous to iCLK.
REQ-008 Port: iSPI_SS_N  input  1  SPI frame select, active-low, asynchronous to iCLK.
REQ-009 Port: iSPI_RCV_CMD  input  8  command byte: [7] 1=read/0=write, [6:3] peripheral id, [2:0] register index.
REQ-010 Port: iSPI_RCV_BYTE  input  8  last data byte received.
REQ-011 Port: oREG_DATA  output  NUM_REGS*REG_BYTES*8  flattened committed registers, register 0 in LSBs, byte 0 LSB.
REQ-012 Port: oREG_UPDATE  output  NUM_REGS  one-cycle commit pulse per register.
REQ-013 Port: oSEND_BYTE  output  8  readback byte for the SPI slave.
REQ-014 Port: oERR  output  1  sticky error flag.

Function
REQ-015 iSPI_WRITE_SIG and iSPI_SS_N SHALL each pass a 2-flop synchroniser; a byte strobe SHALL be the registered rising edge of synchronised iSPI_WRITE_SIG.
REQ-016 iSPI_RCV_CMD and iSPI_RCV_BYTE SHALL be sampled only in the strobe cycle; the SPI clock SHALL be at most iCLK/4 so both are stable then.
REQ-017 A strobe SHALL be ignored unless cmd[6:3]==PERIPH_ID and synchronised SS_N is low.
REQ-018 Write (cmd[7]=0): byte SHALL go into a shadow buffer at byte pointer BP; BP SHALL increment.
REQ-019 When the byte at BP==REG_BYTES-1 is stored, the full shadow SHALL be copied atomically to register cmd[2:0] on the next edge, oREG_UPDATE[idx] SHALL pulse that same cycle for exactly one cycle, and BP SHALL wrap to 0.
REQ-020 Commit latency SHALL be exactly 4 iCLK edges from the first edge sampling iSPI_WRITE_SIG high to oREG_DATA/oREG_UPDATE changing.
REQ-021 Partial multi-byte writes SHALL never be visible on oREG_DATA.
REQ-022 Write with cmd[2:0]>=NUM_REGS and cmd[2:0]!=7 SHALL not modify any register or pulse oREG_UPDATE, and SHALL set oERR.
REQ-023 Read (cmd[7]=1): oSEND_BYTE SHALL present byte RP of register cmd[2:0]; RP SHALL advance on each strobe, wrapping REG_BYTES-1 -> 0.
REQ-024 Read index 7 SHALL return status {oERR, 3'b000, BP[1:0] zero-extended to 4 bits}; read of an unimplemented index SHALL return 8'h00 and set oERR.
REQ-025 Reading status SHALL clear oERR on the strobe after it is returned; a new error in that same cycle SHALL win (oERR stays 1).
REQ-026 Synchronised SS_N rising (frame end) SHALL reset BP and RP to 0 and discard the shadow; it SHALL not alter committed registers.
REQ-027 Strobe and frame end in the same cycle: the strobe SHALL be processed first, then pointers cleared.
REQ-028 oSEND_BYTE SHALL be registered and default to 8'h00 when no read is active.

Reset
REQ-029 While iRESETn low: every register = RST_VAL, oREG_UPDATE = 0, oSEND_BYTE = 8'h00, oERR = 0, BP = RP = 0, shadow = 0, synchronisers = idle (WRITE_SIG 0, SS_N 1).
REQ-030 Reset asserted mid-frame SHALL abort it; after release, bytes SHALL be ignored until an SS_N high->low frame start is seen.

Verification
REQ-031 Defaults, write cmd 8'h09 data 8'h5A -> oREG_DATA[15:8]=8'h5A, oREG_UPDATE=2'b10 one cycle, 4 edges after strobe.
REQ-032 REG_BYTES=2, write cmd 8'h08 bytes 8'h34 then 8'h12 -> oREG_DATA[15:0] holds RST_VAL after byte 1, 16'h1234 after byte 2, single update pulse.
REQ-033 REG_BYTES=2, one byte then SS_N high -> register unchanged, next frame writes from byte 0.
REQ-034 Write cmd 8'h0D (index 5, NUM_REGS=2) -> no register change, oERR=1; read cmd 8'h8F -> 8'h80, then oERR=0.
REQ-035 Assert iRESETn low between bytes of a 2-byte write -> all registers RST_VAL, oERR=0, update never pulses.
REQ-036 Read cmd 8'h88 after writing 8'hA5 -> oSEND_BYTE=8'hA5; foreign id cmd 8'h28 -> ignored, no state change.
